multi_debouncer: RTL and testbench
==================================

MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent input channels (1..32).
REQ-002 SHALL have parameter STABLE_CYCLES, default 16, consecutive identical synchronised samples needed to accept a new level (1..65535).
REQ-003 SHALL have parameter REPEAT_DELAY, default 1000, cycles of held-high before the first repeat pulse (>= 1).
REQ-004 SHALL have parameter REPEAT_PERIOD, default 250, cycles between subsequent repeat pulses (>= 1).
REQ-005 SHALL have port clk  input  1  clock; all state samples on the rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port d  input  N_CH  raw asynchronous inputs (buttons/switches).
REQ-008 SHALL have port q  output  N_CH  debounced level per channel.
REQ-009 SHALL have port rise  output  N_CH  one-cycle pulse when q[i] goes 0->1.
REQ-010 SHALL have port fall  output  N_CH  one-cycle pulse when q[i] goes 1->0.
REQ-011 SHALL have port rpt  output  N_CH  one-cycle auto-repeat pulse while q[i] held high.

Function
REQ-012 SHALL pass each d[i] through a 2-flop synchronizer (s1, s2) before any other use.
REQ-013 SHALL keep a per-channel stability counter; s2==q clears it to 0; s2!=q increments it.
REQ-014 SHALL, when s2!=q and counter == STABLE_CYCLES-1, toggle q[i] to s2 and clear the counter in the same edge.
REQ-015 SHALL therefore update q[i] at edge k+1+STABLE_CYCLES, where edge k first samples the new d[i] level into s1.
REQ-016 SHALL reject any pulse or glitch shorter than STABLE_CYCLES synchronised cycles: q unchanged and counter returned to 0.
REQ-017 SHALL assert rise[i]/fall[i], registered, during exactly the cycle after the edge that changes q[i]; never both together.
REQ-018 SHALL keep the counter saturation-free: width $clog2(STABLE_CYCLES+1), never exceeding STABLE_CYCLES-1.
REQ-019 SHALL operate all channels independently; simultaneous transitions on several channels produce simultaneous pulses.
REQ-020 SHALL (when feature enabled) count held-high cycles from the rise pulse; assert rpt[i] for one cycle at REPEAT_DELAY, then every REPEAT_PERIOD thereafter.
REQ-021 SHALL clear the repeat counter and stop rpt[i] immediately when q[i] falls; rpt never coincides with rise.

Reset
REQ-022 SHALL asynchronously clear s1, s2, q, all counters, rise, fall, rpt to 0 while rst is high.
REQ-023 SHALL treat reset mid-debounce as abort: no pulse on release; an input held high through reset produces rise at edge k+1+STABLE_CYCLES after release.

Configuration
REQ-024 SHALL compile repeat logic only when macro MULTI_DEBOUNCER_AUTOREPEAT_EN is defined.
REQ-025 SHALL, without MULTI_DEBOUNCER_AUTOREPEAT_EN, keep port rpt present but tied to 0, with no repeat counters instantiated; REPEAT_* parameters ignored.

Structure
REQ-026 SHALL place default parameter constants and the counter-width helper in shared package deb_pkg.
REQ-027 SHALL implement one channel (synchronizer, stability counter, edge/repeat logic) in sub-module deb_channel, generated N_CH times.

Verification
REQ-028 SHALL cover: N_CH=4, STABLE_CYCLES=8, d[0] 0->1 held -> q[0]=1 and rise[0] pulse exactly per REQ-015/017, others idle.
REQ-029 SHALL cover: d[1] 5-cycle high glitch, STABLE_CYCLES=8 -> q[1], rise[1], fall[1] stay 0.
REQ-030 SHALL cover: d[2] bouncing 3 toggles within 6 cycles then stable high -> exactly one rise[2], q[2]=1 at 8 cycles after last toggle plus sync latency.
REQ-031 SHALL cover: d[0] and d[3] fall on same edge -> fall[0] and fall[3] pulse same cycle.
REQ-032 SHALL cover: AUTOREPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=5, d held 50 cycles -> rpt pulses at 20, 25, ..., stop on fall; without macro rpt constantly 0.
REQ-033 SHALL cover: rst asserted while counter=5 -> all outputs 0 asynchronously, no pulse after rst release until full re-qualification.

Source files
------------

// File: rtl/deb_pkg.sv
// Shared defaults and sizing helpers for the multi-channel debouncer.
// Used by all debouncer files; the auto-repeat phase type applies only with MULTI_DEBOUNCER_AUTOREPEAT_EN.
package deb_pkg;

   localparam int unsigned DEF_N_CH          = 4;
   localparam int unsigned DEF_STABLE_CYCLES = 16;
   localparam int unsigned DEF_REPEAT_DELAY  = 1000;
   localparam int unsigned DEF_REPEAT_PERIOD = 250;

   typedef enum logic [1:0] {
      RPT_IDLE,
      RPT_DELAY,
      RPT_PERIOD
   } rpt_phase_t;

   // Bits needed to hold values 0..n, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/multi_debouncer_if.sv
// Raw inputs and debounced outputs of the multi-channel debouncer.
// The rpt lines are always present; they are active only with MULTI_DEBOUNCER_AUTOREPEAT_EN.
interface multi_debouncer_if import deb_pkg::*; #(
   parameter int unsigned N_CH = DEF_N_CH
);
   logic [N_CH-1:0] d;
   logic [N_CH-1:0] q;
   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] fall;
   logic [N_CH-1:0] rpt;

   modport master (output d, input q, rise, fall, rpt);
   modport slave  (input d, output q, rise, fall, rpt);
endinterface

// File: rtl/deb_channel.sv
// One debounce channel: 2-flop synchronizer, stability counter, edge pulses.
// Auto-repeat counter is built only when MULTI_DEBOUNCER_AUTOREPEAT_EN is defined.
module deb_channel import deb_pkg::*; #(
   parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
   ,
   parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall,
   output logic rpt
);
   localparam int unsigned   CW   = cnt_width(STABLE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

   logic          s1;
   logic          s2;
   logic [CW-1:0] cnt;
   logic          flip;

   assign flip = (s2 != q) && (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         q    <= 1'b0;
         cnt  <= '0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         s1   <= d;
         s2   <= s1;
         rise <= flip && s2;
         fall <= flip && !s2;
         if ((s2 == q) || flip)
            cnt <= '0;
         else
            cnt <= cnt + CW'(1);
         if (flip)
            q <= s2;
      end
   end

`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
   localparam int unsigned   RW          = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));
   localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

   rpt_phase_t    phase;
   logic [RW-1:0] rcnt;

   // Counting restarts on the edge that raises q, so rpt lands REPEAT_DELAY cycles after rise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase <= RPT_IDLE;
         rcnt  <= '0;
         rpt   <= 1'b0;
      end else if (flip) begin
         phase <= s2 ? RPT_DELAY : RPT_IDLE;
         rcnt  <= '0;
         rpt   <= 1'b0;
      end else if (phase == RPT_IDLE) begin
         rpt <= 1'b0;
      end else if (rcnt == ((phase == RPT_DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
         phase <= RPT_PERIOD;
         rcnt  <= '0;
         rpt   <= 1'b1;
      end else begin
         rcnt <= rcnt + RW'(1);
         rpt  <= 1'b0;
      end
   end
`else
   assign rpt = 1'b0;
`endif

endmodule

// File: rtl/multi_debouncer.sv
// N_CH independent debounced inputs with rise/fall pulses and optional auto-repeat.
// Auto-repeat is compiled in only when MULTI_DEBOUNCER_AUTOREPEAT_EN is defined; otherwise rpt reads 0.
module multi_debouncer import deb_pkg::*; #(
   parameter int unsigned N_CH          = DEF_N_CH,
   parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
   input logic              clk,
   input logic              rst,
   multi_debouncer_if.slave bus
);
   if (N_CH < 1 || N_CH > 32) begin : g_bad_n_ch
      $error("multi_debouncer: N_CH must be 1..32");
   end
   if (STABLE_CYCLES < 1 || STABLE_CYCLES > 65535) begin : g_bad_stable
      $error("multi_debouncer: STABLE_CYCLES must be 1..65535");
   end
   if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
      $error("multi_debouncer: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
   end

   logic [N_CH-1:0] q_v;
   logic [N_CH-1:0] rise_v;
   logic [N_CH-1:0] fall_v;
   logic [N_CH-1:0] rpt_v;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      deb_channel #(
         .STABLE_CYCLES(STABLE_CYCLES)
`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
         ,
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
      ) u_ch (
         .clk (clk),
         .rst (rst),
         .d   (bus.d[g]),
         .q   (q_v[g]),
         .rise(rise_v[g]),
         .fall(fall_v[g]),
         .rpt (rpt_v[g])
      );
   end

   assign bus.q    = q_v;
   assign bus.rise = rise_v;
   assign bus.fall = fall_v;
   assign bus.rpt  = rpt_v;

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer (N_CH=4, STABLE_CYCLES=8, REPEAT 20/5).
// Expected rpt pulses are added only when MULTI_DEBOUNCER_AUTOREPEAT_EN is defined.
module tb_multi_debouncer;
   localparam int unsigned STABLE = 8;
   localparam int unsigned LAT    = STABLE + 2;
   localparam int unsigned RD     = 20;
   localparam int unsigned RP     = 5;

   typedef struct {
      int unsigned cyc;
      logic [3:0]  rise;
      logic [3:0]  fall;
      logic [3:0]  rpt;
   } ev_t;

   logic        clk;
   logic        rst;
   int unsigned cyc;
   int unsigned n_assert;
   int unsigned n_fail;
   ev_t         sb[$];

   multi_debouncer_if #(.N_CH(4)) bus ();

   multi_debouncer #(
      .N_CH         (4),
      .STABLE_CYCLES(STABLE),
      .REPEAT_DELAY (RD),
      .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Merge an expected pulse pattern into the time-ordered scoreboard.
   function automatic void add_ev(input int unsigned t, input logic [3:0] r,
                                  input logic [3:0] f, input logic [3:0] p);
      ev_t         e;
      int unsigned i;
      i = 0;
      while (i < sb.size() && sb[i].cyc < t) i++;
      if (i < sb.size() && sb[i].cyc == t) begin
         e = sb[i];
         e.rise |= r;
         e.fall |= f;
         e.rpt  |= p;
         sb[i] = e;
      end else begin
         e.cyc  = t;
         e.rise = r;
         e.fall = f;
         e.rpt  = p;
         sb.insert(i, e);
      end
   endfunction

   always @(negedge clk) begin
      ev_t e;
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
         e = sb.pop_front();
         chk("rise pulse", {28'd0, bus.rise}, {28'd0, e.rise});
         chk("fall pulse", {28'd0, bus.fall}, {28'd0, e.fall});
         chk("rpt pulse",  {28'd0, bus.rpt},  {28'd0, e.rpt});
      end else begin
         chk("no pulse expected", {20'd0, bus.rise, bus.fall, bus.rpt}, 32'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic idle(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   // Press mask m for n cycles; checks q around both qualification edges.
   task automatic hold(input logic [3:0] m, input int unsigned n, input string tag);
      int unsigned c, r, f;
      c = cyc;
      r = c + LAT;
      f = c + n + LAT;
      bus.d = bus.d | m;
      add_ev(r, m, 4'd0, 4'd0);
      add_ev(f, 4'd0, m, 4'd0);
`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
      for (int unsigned t = r + RD; t < f; t += RP) add_ev(t, 4'd0, 4'd0, m);
`endif
      while (cyc < f) begin
         @(negedge clk);
         if (cyc == c + n) bus.d = bus.d & ~m;
         if (cyc == r - 1) chk({tag, " q before rise"}, {28'd0, bus.q & m}, 32'd0);
         if (cyc == r)     chk({tag, " q at rise"},     {28'd0, bus.q & m}, {28'd0, m});
         if (cyc == f - 1) chk({tag, " q before fall"}, {28'd0, bus.q & m}, {28'd0, m});
         if (cyc == f)     chk({tag, " q at fall"},     {28'd0, bus.q & m}, 32'd0);
      end
   endtask

   initial begin
      int unsigned c;
      int unsigned r;
      n_assert = 0;
      n_fail   = 0;
      rst      = 1'b1;
      bus.d    = 4'd0;

      idle(3);
      chk("reset q",    {28'd0, bus.q},    32'd0);
      chk("reset rise", {28'd0, bus.rise}, 32'd0);
      chk("reset fall", {28'd0, bus.fall}, 32'd0);
      chk("reset rpt",  {28'd0, bus.rpt},  32'd0);
      rst = 1'b0;
      idle(3);

      hold(4'b0001, 50, "ch0 press");
      idle(3);

      bus.d[1] = 1'b1;
      idle(5);
      bus.d[1] = 1'b0;
      idle(14);
      chk("glitch5 q", {28'd0, bus.q}, 32'd0);

      bus.d[2] = 1'b1;
      idle(7);
      bus.d[2] = 1'b0;
      idle(14);
      chk("glitch7 q", {28'd0, bus.q}, 32'd0);

      hold(4'b0010, 8, "ch1 min pulse");
      idle(3);

      bus.d[2] = 1'b1;
      idle(2);
      bus.d[2] = 1'b0;
      idle(2);
      bus.d[2] = 1'b1;
      c = cyc;
      add_ev(c + LAT, 4'b0100, 4'd0, 4'd0);
      add_ev(c + 2 * LAT, 4'd0, 4'b0100, 4'd0);
      idle(LAT - 1);
      chk("bounce q before", {28'd0, bus.q}, 32'd0);
      idle(1);
      chk("bounce q after", {28'd0, bus.q}, 32'h4);
      bus.d[2] = 1'b0;
      idle(LAT);
      chk("bounce q released", {28'd0, bus.q}, 32'd0);
      idle(3);

      hold(4'b1001, 12, "ch0+ch3");
      idle(3);

      bus.d[3] = 1'b1;
      add_ev(cyc + LAT, 4'b1000, 4'd0, 4'd0);
      idle(LAT);
      chk("pre-reset q", {28'd0, bus.q}, 32'h8);
      bus.d[1] = 1'b1;
      idle(7);
      rst = 1'b1;
      #1;
      chk("async reset q",    {28'd0, bus.q},    32'd0);
      chk("async reset rise", {28'd0, bus.rise}, 32'd0);
      chk("async reset fall", {28'd0, bus.fall}, 32'd0);
      idle(3);
      rst = 1'b0;
      r = cyc;
      add_ev(r + LAT, 4'b1010, 4'd0, 4'd0);
      idle(LAT - 1);
      chk("requal q before", {28'd0, bus.q}, 32'd0);
      idle(1);
      chk("requal q after", {28'd0, bus.q}, 32'ha);
      bus.d = 4'd0;
      add_ev(cyc + LAT, 4'd0, 4'b1010, 4'd0);
      idle(LAT);
      chk("requal q released", {28'd0, bus.q}, 32'd0);

      idle(5);
      chk("scoreboard drained", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
